data_mem_pipe: RTL

Parametrised, byte-addressed, big-endian data memory for the CPU pipeline's MEM stage. It replaces the fixed 16-bit single-cycle data memory and adds configurable data width and depth, per-byte write enables, a valid/ready request handshake, and a configurable read-latency pipeline. It also adds a hardware clear-and-preload sequencer that runs after reset. All state is updated on the falling edge of `clk`, so rising-edge pipeline registers capture the read data half a cycle later.

---
 rtl/data_mem_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_pipe.sv
// Byte-addressed big-endian data memory with valid/ready requests, a read-latency shift
// pipeline and a post-reset clear/preload sequencer (build with DATA_MEM_PIPE_INIT_EN).
module data_mem_pipe #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 256,
    parameter int                RD_LAT    = 1,
    parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(16'h2BCD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int BYTES = DATA_W / 8;
    localparam int AW_M  = $clog2(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic              w_run;
    logic              w_clr;
    logic              w_load;
    logic [AW_M-1:0]   w_clr_base;
    logic              w_acc;
    logic              w_in_range;
    logic [AW_M-1:0]   w_lane_idx [BYTES];
    logic [DATA_W-1:0] w_rdata;
    logic [BYTES-1:0]  w_wr_en;
    logic [AW_M-1:0]   w_wr_idx [BYTES];
    logic [7:0]        w_wr_byte [BYTES];

`ifdef DATA_MEM_PIPE_INIT_EN
    localparam int NWORDS = DEPTH / BYTES;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {INIT_CLR, INIT_LOAD, RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= INIT_CLR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            INIT_CLR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(NWORDS - 1)) w_state_nxt = INIT_LOAD;
            end
            INIT_LOAD: w_state_nxt = RUN;
            RUN:       w_state_nxt = RUN;
            default:   w_state_nxt = INIT_CLR;
        endcase
    end

    assign w_run      = (r_state == RUN);
    assign w_clr      = (r_state == INIT_CLR);
    assign w_load     = (r_state == INIT_LOAD);
    assign w_clr_base = AW_M'(r_cnt) * AW_M'(BYTES);
`else
    logic r_run;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    assign w_run      = r_run;
    assign w_clr      = 1'b0;
    assign w_load     = 1'b0;
    assign w_clr_base = '0;
`endif

    assign req_ready  = w_run;
    assign init_done  = w_run;
    assign w_acc      = req_valid && w_run;
    assign w_in_range = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));

    // Lane k (MSB lane = BYTES-1) sits at byte offset BYTES-1-k; the sum wraps modulo DEPTH.
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < BYTES; k++) begin
            w_lane_idx[k]    = req_addr[AW_M-1:0] + AW_M'(BYTES - 1 - k);
            w_rdata[k*8 +: 8] = w_in_range ? r_mem[w_lane_idx[k]] : 8'h00;
        end
    end

    always_comb begin
        for (int k = 0; k < BYTES; k++) begin
            w_wr_en[k]   = 1'b0;
            w_wr_idx[k]  = w_lane_idx[k];
            w_wr_byte[k] = req_wdata[k*8 +: 8];
            if (w_clr) begin
                w_wr_en[k]   = 1'b1;
                w_wr_idx[k]  = w_clr_base + AW_M'(BYTES - 1 - k);
                w_wr_byte[k] = 8'h00;
            end else if (w_load) begin
                w_wr_en[k]   = 1'b1;
                w_wr_idx[k]  = AW_M'(BYTES - 1 - k);
                w_wr_byte[k] = INIT_WORD[k*8 +: 8];
            end else begin
                w_wr_en[k]   = w_acc && req_we && w_in_range && req_be[k];
            end
        end
    end

    always_ff @(negedge clk) begin
        for (int k = 0; k < BYTES; k++) begin
            if (w_wr_en[k]) r_mem[w_wr_idx[k]] <= w_wr_byte[k];
        end
    end

    logic [RD_LAT-1:0] r_vld_p;
    logic [RD_LAT-1:0] r_err_p;
    logic [DATA_W-1:0] r_rdata_p [RD_LAT];

    // Data stages load only behind a valid bit so the output holds its last response.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p <= '0;
            r_err_p <= '0;
            for (int i = 0; i < RD_LAT; i++) r_rdata_p[i] <= '0;
        end else begin
            r_vld_p[0] <= w_acc && !req_we;
            if (w_acc && !req_we) begin
                r_rdata_p[0] <= w_rdata;
                r_err_p[0]   <= !w_in_range;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
                if (r_vld_p[i-1]) begin
                    r_rdata_p[i] <= r_rdata_p[i-1];
                    r_err_p[i]   <= r_err_p[i-1];
                end
            end
        end
    end

    assign rsp_valid = r_vld_p[RD_LAT-1];
    assign rsp_rdata = r_rdata_p[RD_LAT-1];
    assign rsp_err   = r_err_p[RD_LAT-1];

endmodule
